// File: rtl/clock_mode_sequencer.sv
// clock_mode_sequencer
//
// Purpose:
//   Walks a group of clock output nodes through a clock-mode change. On an
//   accepted request it stops every function clock, pulses the reset clocks
//   of the selected nodes for RESET_CYCLES once they are all running, stops
//   the reset clocks again, and then restarts the selected function clocks
//   one at a time in ascending node order with at least STAGGER_CYCLES
//   between a node reporting ready and the next node being enabled. A single
//   mode_entered pulse marks completion.
//
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   next_mode/next_mode_ready request handshake (ready only while idle)
//   mode_reset_mask           nodes that receive a reset-clock pulse
//   mode_func_mask            nodes whose function clock runs in the new mode
//   mode_entered              one-cycle completion pulse
//   enable_reset_clock        per-node reset-clock enable
//   enable_function_clock     per-node function-clock enable
//   clock_ready_for_reset     per-node reset clock running
//   clock_silent_for_reset    per-node reset clock stopped
//   clock_ready               per-node function clock running
//   clock_silent              per-node function clock stopped
//   busy                      sequence in progress
//   timeout_error             sticky watchdog flag
//
// Configuration:
//   CLOCK_SEQ_TIMEOUT_EN  when defined, each waiting state is bounded by
//                         TIMEOUT_CYCLES; on expiry the sequence is abandoned
//                         with all enables low and timeout_error set. When
//                         undefined, waits are unbounded and timeout_error
//                         is tied low.
//
// All outputs come straight from flops loaded with next-state values, so they
// line up with the state register.

module clock_mode_sequencer #(
  parameter int N_CLOCKS       = 4,
  parameter int RESET_CYCLES   = 8,
  parameter int STAGGER_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                next_mode,
  output logic                next_mode_ready,
  input  logic [N_CLOCKS-1:0] mode_reset_mask,
  input  logic [N_CLOCKS-1:0] mode_func_mask,
  output logic                mode_entered,
  output logic [N_CLOCKS-1:0] enable_reset_clock,
  output logic [N_CLOCKS-1:0] enable_function_clock,
  input  logic [N_CLOCKS-1:0] clock_ready_for_reset,
  input  logic [N_CLOCKS-1:0] clock_silent_for_reset,
  input  logic [N_CLOCKS-1:0] clock_ready,
  input  logic [N_CLOCKS-1:0] clock_silent,
  output logic                busy,
  output logic                timeout_error
);

  localparam int MAX_CNT = (RESET_CYCLES > STAGGER_CYCLES) ? RESET_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = (N_CLOCKS > 1) ? $clog2(N_CLOCKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLOCKS - 1);

  // FUNC_ON is split into scan / wait-for-ready / stagger-gap sub-states.
  typedef enum logic [3:0] {
    S_IDLE,
    S_STOP_FUNC,
    S_RESET_ON,
    S_HOLD,
    S_RESET_OFF,
    S_FUNC_SCAN,
    S_FUNC_WAIT,
    S_FUNC_GAP,
    S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [N_CLOCKS-1:0] rmask_reg, rmask_next;
  logic [N_CLOCKS-1:0] fmask_reg, fmask_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [N_CLOCKS-1:0] erc_reg, erc_next;
  logic [N_CLOCKS-1:0] efc_reg, efc_next;
  logic                entered_reg, busy_reg, ready_reg;
  logic                accept;
  logic                step_idx;

  assign accept = next_mode && (state_reg == S_IDLE);

`ifdef CLOCK_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_reg, wd_next;
  logic            waiting;
  logic            wd_expired;
  logic            timeout_hit;
  logic            terr_reg;

  // Only states that depend on node status can stall indefinitely.
  assign waiting    = state_reg inside {S_STOP_FUNC, S_RESET_ON, S_RESET_OFF, S_FUNC_WAIT};
  assign wd_expired = waiting && (wd_reg == '0);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_next = state_reg;
    rmask_next = rmask_reg;
    fmask_next = fmask_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    erc_next   = erc_reg;
    efc_next   = efc_reg;
    step_idx   = 1'b0;
`ifdef CLOCK_SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          rmask_next = mode_reset_mask;
          fmask_next = mode_func_mask;
          efc_next   = '0;
          erc_next   = '0;
          state_next = S_STOP_FUNC;
        end
      end
      S_STOP_FUNC: begin
        if (&clock_silent) begin
          if (rmask_reg != '0) begin
            erc_next   = rmask_reg;
            state_next = S_RESET_ON;
          end else begin
            idx_next   = '0;
            state_next = S_FUNC_SCAN;
          end
        end
      end
      S_RESET_ON: begin
        if ((clock_ready_for_reset & rmask_reg) == rmask_reg) begin
          cnt_next   = CNT_W'(RESET_CYCLES - 1);
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_reg == '0) begin
          erc_next   = '0;
          state_next = S_RESET_OFF;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      S_RESET_OFF: begin
        if (&clock_silent_for_reset) begin
          idx_next   = '0;
          state_next = S_FUNC_SCAN;
        end
      end
      S_FUNC_SCAN: begin
        // Unselected nodes are skipped one per cycle.
        if (fmask_reg[idx_reg]) begin
          efc_next[idx_reg] = 1'b1;
          state_next        = S_FUNC_WAIT;
        end else begin
          step_idx = 1'b1;
        end
      end
      S_FUNC_WAIT: begin
        if (clock_ready[idx_reg]) begin
          if (STAGGER_CYCLES > 0) begin
            cnt_next   = CNT_W'(STAGGER_CYCLES - 1);
            state_next = S_FUNC_GAP;
          end else begin
            step_idx = 1'b1;
          end
        end
      end
      S_FUNC_GAP: begin
        if (cnt_reg == '0) begin
          step_idx = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Advance to the next node, or finish after the last one.
    if (step_idx) begin
      if (idx_reg == LAST_IDX) begin
        state_next = S_DONE;
      end else begin
        idx_next   = idx_reg + IDX_W'(1);
        state_next = S_FUNC_SCAN;
      end
    end

`ifdef CLOCK_SEQ_TIMEOUT_EN
    // Expiry only counts while the wait condition is still unmet.
    if (wd_expired && (state_next == state_reg)) begin
      timeout_hit = 1'b1;
      erc_next    = '0;
      efc_next    = '0;
      state_next  = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      rmask_reg   <= '0;
      fmask_reg   <= '0;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      erc_reg     <= '0;
      efc_reg     <= '0;
      entered_reg <= 1'b0;
      busy_reg    <= 1'b0;
      ready_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      rmask_reg   <= rmask_next;
      fmask_reg   <= fmask_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      erc_reg     <= erc_next;
      efc_reg     <= efc_next;
      entered_reg <= (state_next == S_DONE);
      busy_reg    <= (state_next != S_IDLE);
      ready_reg   <= (state_next == S_IDLE);
    end
  end

`ifdef CLOCK_SEQ_TIMEOUT_EN
  // Down-counter reloaded on every state change; stops at zero.
  always_comb begin
    wd_next = wd_reg;
    if (state_next != state_reg) begin
      wd_next = WD_W'(TIMEOUT_CYCLES - 1);
    end else if (wd_reg != '0) begin
      wd_next = wd_reg - WD_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_reg   <= '0;
      terr_reg <= 1'b0;
    end else begin
      wd_reg <= wd_next;
      if (timeout_hit) begin
        terr_reg <= 1'b1;
      end else if (accept) begin
        terr_reg <= 1'b0;
      end
    end
  end

  assign timeout_error = terr_reg;
`else
  assign timeout_error = 1'b0;
`endif

  assign next_mode_ready       = ready_reg;
  assign mode_entered          = entered_reg;
  assign enable_reset_clock    = erc_reg;
  assign enable_function_clock = efc_reg;
  assign busy                  = busy_reg;

endmodule
